// File: rtl/math_multiplier_shiftadd.sv
// Iterative unsigned NxN shift-and-add multiplier: one add-and-shift per clock,
// exact 2N-bit product after N iterations, built on a ripple-carry adder.
module math_multiplier_shiftadd #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   p
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    m_q;
    logic [PW-1:0]   pp_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    addend;
    logic [N:0]      add_s;
    logic [PW-1:0]   pp_shift;
    logic            last_iter;
    logic            accept;
    logic            busy_d;
    logic            done_d;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    assign addend    = pp_q[0] ? m_q : '0;
    assign last_iter = (cnt_q == CW'(1));

    math_adder_ripple #(
        .N (N)
    ) u_add (
        .a  (pp_q[PW-1:N]),
        .b  (addend),
        .ci (1'b0),
        .s  (add_s)
    );

    // The carry s[N] becomes the new MSB, so the result is exact for all operands.
    assign pp_shift = {add_s, pp_q[N-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (last_iter) state_next = S_DONE;
            S_DONE: state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state == S_IDLE) || (state == S_DONE)) begin
            accept = start;
        end
        busy_d = (state_next == S_RUN);
        done_d = (state_next == S_DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            pp_q  <= '0;
            cnt_q <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (accept) begin
                m_q   <= a;
                pp_q  <= {N'(0), b};
                cnt_q <= CW'(N);
            end else if (state == S_RUN) begin
                pp_q  <= pp_shift;
                cnt_q <= cnt_q - CW'(1);
                if (last_iter) begin
                    p <= pp_shift;
                end
            end
        end
    end

endmodule

// N-bit ripple-carry adder with the carry-out folded in as sum bit N.
module math_adder_ripple #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N:0]   s
);

    logic carry;

    always_comb begin
        s     = '0;
        carry = ci;
        for (int i = 0; i < int'(N); i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        s[N] = carry;
    end

endmodule

// File: tb/tb_math_multiplier_shiftadd.sv
// Self-checking bench for math_multiplier_shiftadd: directed and randomized
// operands at N=4 and N=8, checked cycle by cycle against a plain a*b model.
module tb_math_multiplier_shiftadd;

    localparam int unsigned N4 = 4;
    localparam int unsigned N8 = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start4;
    logic [3:0]    a4, b4;
    logic          busy4, done4;
    logic [7:0]    p4;
    logic          start8;
    logic [7:0]    a8, b8;
    logic          busy8, done8;
    logic [15:0]   p8;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  last_p4;
    logic [15:0] last_p8;

    math_multiplier_shiftadd #(.N(N4)) dut4 (
        .clk (clk), .rst (rst), .start (start4), .a (a4), .b (b4),
        .busy (busy4), .done (done4), .p (p4)
    );

    math_multiplier_shiftadd #(.N(N8)) dut8 (
        .clk (clk), .rst (rst), .start (start8), .a (a8), .b (b8),
        .busy (busy8), .done (done8), .p (p8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N=4 operation with cycle-exact checks and a stray start during RUN.
    task automatic do4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] expv;
        int poke;
        expv = 8'(x) * 8'(y);
        poke = int'($urandom_range(N4 - 1, 0));
        start4 = 1'b1; a4 = x; b4 = y;
        tick();
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        for (int i = 0; i < int'(N4); i++) begin
            chk("busy4_run", 64'(busy4), 64'(1));
            chk("done4_run", 64'(done4), 64'(0));
            chk("p4_hold_run", 64'(p4), 64'(last_p4));
            if (i == poke) begin
                start4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            end else begin
                start4 = 1'b0;
            end
            tick();
        end
        start4 = 1'b0;
        chk("busy4_done", 64'(busy4), 64'(0));
        chk("done4_pulse", 64'(done4), 64'(1));
        chk("p4_product", 64'(p4), 64'(expv));
        last_p4 = expv;
        tick();
        chk("done4_after", 64'(done4), 64'(0));
        chk("busy4_after", 64'(busy4), 64'(0));
        chk("p4_hold_after", 64'(p4), 64'(expv));
    endtask

    task automatic do8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] expv;
        expv = 16'(x) * 16'(y);
        start8 = 1'b1; a8 = x; b8 = y;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < int'(N8); i++) begin
            chk("busy8_run", 64'(busy8), 64'(1));
            chk("p8_hold_run", 64'(p8), 64'(last_p8));
            tick();
        end
        chk("done8_pulse", 64'(done8), 64'(1));
        chk("p8_product", 64'(p8), 64'(expv));
        last_p8 = expv;
        tick();
        chk("done8_after", 64'(done8), 64'(0));
    endtask

    initial begin
        logic [7:0] order [256];
        logic [7:0] tmp;
        int j;

        rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        last_p4 = '0; last_p8 = '0;
        tick(); tick();
        chk("rst_busy4", 64'(busy4), 64'(0));
        chk("rst_done4", 64'(done4), 64'(0));
        chk("rst_p4", 64'(p4), 64'(0));
        chk("rst_busy8", 64'(busy8), 64'(0));
        chk("rst_p8", 64'(p8), 64'(0));
        rst = 1'b0;
        tick();

        do4(4'd3, 4'd5);
        do4(4'd15, 4'd15);
        do4(4'd0, 4'd9);
        do4(4'd9, 4'd0);
        do4(4'd5, 4'd3);
        do8(8'd255, 8'd255);
        do8(8'd0, 8'd200);
        for (int k = 0; k < 6; k++) do8(8'($urandom), 8'($urandom));

        // Start held high: operands changed during RUN are only seen at the next accept.
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd7;
        tick();
        a4 = 4'd6; b4 = 4'd6;
        for (int i = 0; i < int'(N4); i++) tick();
        chk("b2b_done1", 64'(done4), 64'(1));
        chk("b2b_p1", 64'(p4), 64'(14));
        tick();
        chk("b2b_busy2", 64'(busy4), 64'(1));
        chk("b2b_done_low", 64'(done4), 64'(0));
        a4 = 4'd13; b4 = 4'd11;
        for (int i = 0; i < int'(N4); i++) tick();
        chk("b2b_done2", 64'(done4), 64'(1));
        chk("b2b_p2", 64'(p4), 64'(36));
        tick();
        a4 = 4'($urandom); b4 = 4'($urandom);
        for (int i = 0; i < int'(N4); i++) tick();
        chk("b2b_done3", 64'(done4), 64'(1));
        chk("b2b_p3", 64'(p4), 64'(143));
        start4 = 1'b0;
        tick();
        chk("b2b_idle_busy", 64'(busy4), 64'(0));
        chk("b2b_idle_done", 64'(done4), 64'(0));
        last_p4 = 8'd143;

        // Abort mid-operation: reset clears everything and no done follows.
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
        tick();
        start4 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy4), 64'(0));
        chk("abort_done", 64'(done4), 64'(0));
        chk("abort_p", 64'(p4), 64'(0));
        for (int i = 0; i < int'(N4) + 2; i++) begin
            tick();
            chk("abort_no_done", 64'(done4), 64'(0));
            chk("abort_no_busy", 64'(busy4), 64'(0));
        end
        last_p4 = '0;
        last_p8 = '0;
        do4(4'd4, 4'd4);

        // Every operand pair, in shuffled order.
        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) do4(order[i][7:4], order[i][3:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
